// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory behind a valid/ready request port, with programmable wait states.
// Latency: a legal access responds WAIT_STATES+1 edges after accept (the accept edge counts as the first); an error responds on the accept edge.
// Backpressure: req_ready is high only in IDLE. The response is a single-cycle pulse and cannot be stalled.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_wr              1 = store, 0 = load
//   i_req_size            00 byte, 01 half, 10 word, 11 reserved (error)
//   i_req_signed          load extension: 1 = sign-extend, 0 = zero-extend
//   i_req_addr            byte address
//   i_req_wdata           store data, right-aligned
//   o_rsp_valid           one-cycle response pulse
//   o_rsp_rdata           load data, right-aligned and extended; 0 for stores and errors
//   o_rsp_err             the access was rejected (qualifies o_rsp_valid)
//   o_err_count           saturating count of error responses
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [7:0]  o_err_count
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_mem [DEPTH];

  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [7:0]  r_err_count;

  logic        w_accept;
  logic        w_wr;
  logic [1:0]  w_size;
  logic        w_signed;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic        w_to_resp;
  logic        w_commit;
  logic [ADDR_WIDTH-1:0] w_idx0;
  logic [ADDR_WIDTH-1:0] w_idx1;
  logic [ADDR_WIDTH-1:0] w_idx2;
  logic [ADDR_WIDTH-1:0] w_idx3;
  logic [7:0]  w_b0;
  logic [7:0]  w_b1;
  logic [7:0]  w_b2;
  logic [7:0]  w_b3;
  logic [31:0] w_load;

  // Ready is forced low while reset is held, even though the state register already reads IDLE.
  assign o_req_ready = rst_n && (r_state == S_IDLE);
  assign w_accept    = i_req_valid && o_req_ready;

  // With zero wait states the access completes on the accept edge itself, so the live request
  // fields must drive the memory in IDLE; otherwise the latched copy is used.
  assign w_wr     = (r_state == S_IDLE) ? i_req_wr     : r_wr;
  assign w_size   = (r_state == S_IDLE) ? i_req_size   : r_size;
  assign w_signed = (r_state == S_IDLE) ? i_req_signed : r_signed;
  assign w_addr   = (r_state == S_IDLE) ? i_req_addr   : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? i_req_wdata  : r_wdata;

  always_comb begin
    w_err = 1'b0;
    if (w_size == 2'b11)                             w_err = 1'b1;
    if ((w_size == 2'b01) && w_addr[0])              w_err = 1'b1;
    if ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
    if ((w_addr >> ADDR_WIDTH) != 32'd0)             w_err = 1'b1;
  end

  // Only legal requests are latched into WAIT, so w_err is always 0 there.
  always_comb begin
    w_to_resp = 1'b0;
    case (r_state)
      S_IDLE:  w_to_resp = w_accept && (w_err || (WAIT_STATES == 0));
      S_WAIT:  w_to_resp = (r_cnt == 4'd0);
      default: w_to_resp = 1'b0;
    endcase
  end

  assign w_commit = w_to_resp && !w_err;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err || (WAIT_STATES == 0)) w_next = S_RESP;
          else                             w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter, response data and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr        <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_err       <= 1'b0;
      r_cnt       <= 4'd0;
      r_rdata     <= 32'd0;
      r_err_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_wr     <= i_req_wr;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_err    <= w_err;
        r_cnt    <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_to_resp) begin
        r_rdata <= (w_commit && !w_wr) ? w_load : 32'd0;
      end

      if (w_to_resp && w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Byte lanes, lowest address first. A legal aligned access never crosses the top of the
  // array; the wrapped indices for narrower accesses are read but never used.
  assign w_idx0 = w_addr[ADDR_WIDTH-1:0];
  assign w_idx1 = w_idx0 + ADDR_WIDTH'(1);
  assign w_idx2 = w_idx0 + ADDR_WIDTH'(2);
  assign w_idx3 = w_idx0 + ADDR_WIDTH'(3);

  assign w_b0 = r_mem[w_idx0];
  assign w_b1 = r_mem[w_idx1];
  assign w_b2 = r_mem[w_idx2];
  assign w_b3 = r_mem[w_idx3];

  always_comb begin
    w_load = 32'd0;
    case (w_size)
      2'b00:   w_load = {{24{w_signed & w_b0[7]}}, w_b0};
      2'b01:   w_load = {{16{w_signed & w_b0[7]}}, w_b0, w_b1};
      default: w_load = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // Byte array: not reset, so an access aborted by reset leaves it untouched.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr) begin
      case (w_size)
        2'b00: r_mem[w_idx0] <= w_wdata[7:0];
        2'b01: begin
          r_mem[w_idx0] <= w_wdata[15:8];
          r_mem[w_idx1] <= w_wdata[7:0];
        end
        2'b10: begin
          r_mem[w_idx0] <= w_wdata[31:24];
          r_mem[w_idx1] <= w_wdata[23:16];
          r_mem[w_idx2] <= w_wdata[15:8];
          r_mem[w_idx3] <= w_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_err   = o_rsp_valid && r_err;
  assign o_rsp_rdata = o_rsp_valid ? r_rdata : 32'd0;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: directed vector table on a two-wait-state instance plus hand-written
// sequences for saturation, held-valid throughput, zero-wait back-to-back traffic and reset abort.
module tb_data_mem_ctrl;

  logic clk;
  logic rst_n;

  // Instance A: WAIT_STATES = 2
  logic        a_valid, a_ready, a_wr, a_signed;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rsp_valid, a_err;
  logic [7:0]  a_err_count;

  // Instance B: WAIT_STATES = 0
  logic        b_valid, b_ready, b_wr, b_signed;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_rsp_valid, b_err;
  logic [7:0]  b_err_count;

  int n_chk;
  int n_err;
  int cyc;

  data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(2), .INIT_FILE("")) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_wr(a_wr), .i_req_size(a_size),
    .i_req_signed(a_signed), .i_req_addr(a_addr), .i_req_wdata(a_wdata),
    .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rdata), .o_rsp_err(a_err), .o_err_count(a_err_count)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0), .INIT_FILE("")) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_wr(b_wr), .i_req_size(b_size),
    .i_req_signed(b_signed), .i_req_addr(b_addr), .i_req_wdata(b_wdata),
    .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rdata), .o_rsp_err(b_err), .o_err_count(b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on instance A. Entered and left at a negedge. lat counts edges from the accept
  // edge (counted as 1) to the edge that raises rsp_valid; 99 means no response arrived.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    rd  = 32'd0;
    er  = 1'b0;
    lat = 99;
    while (!a_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("ready_timeout", 32'(a_ready), 32'd1);
      return;
    end
    a_valid = 1'b1; a_wr = wr; a_size = size; a_signed = sgn; a_addr = addr; a_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Scramble the fields after accept: the response must come from the latched copy.
    a_valid = 1'b0; a_wr = ~wr; a_size = ~size; a_signed = ~sgn;
    a_addr = 32'h0000_0001; a_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!a_rsp_valid) begin
      lat = 99;
      return;
    end
    rd = a_rdata;
    er = a_err;
    @(negedge clk);
    check("rsp_single_pulse", 32'(a_rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  vec_t v[24];
  vec_t vb[5];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nerr_seen;
    int          rsp_cnt;
    int          rsp_at[4];
    int          last_cyc;
    int          guard;

    n_chk = 0;
    n_err = 0;

    //              wr    size  sgn   addr           wdata          exp_rdata      err   lat
    v[0]  = '{1'b1, SZ_W, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 3};
    v[1]  = '{1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
    v[2]  = '{1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    v[3]  = '{1'b0, SZ_B, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_00DE, 1'b0, 3};
    v[4]  = '{1'b0, SZ_B, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_00AD, 1'b0, 3};
    v[5]  = '{1'b0, SZ_B, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_00BE, 1'b0, 3};
    v[6]  = '{1'b0, SZ_B, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_00EF, 1'b0, 3};
    v[7]  = '{1'b0, SZ_B, 1'b1, 32'h0000_0011, 32'h0,         32'hFFFF_FFAD, 1'b0, 3};
    v[8]  = '{1'b1, SZ_H, 1'b0, 32'h0000_0012, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 3};
    v[9]  = '{1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_1234, 1'b0, 3};
    v[10] = '{1'b0, SZ_H, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_DEAD, 1'b0, 3};
    v[11] = '{1'b0, SZ_H, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_1234, 1'b0, 3};
    v[12] = '{1'b0, SZ_H, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 1};
    v[13] = '{1'b1, SZ_W, 1'b0, 32'h0000_0012, 32'h5555_5555, 32'h0000_0000, 1'b1, 1};
    v[14] = '{1'b0, SZ_R, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1};
    v[15] = '{1'b1, SZ_W, 1'b0, 32'h0000_0410, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1};
    v[16] = '{1'b0, SZ_W, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_1234, 1'b0, 3};
    v[17] = '{1'b1, SZ_W, 1'b0, 32'h0000_03FC, 32'h0102_0304, 32'h0000_0000, 1'b0, 3};
    v[18] = '{1'b1, SZ_B, 1'b0, 32'h0000_03FD, 32'hFFFF_FF80, 32'h0000_0000, 1'b0, 3};
    v[19] = '{1'b0, SZ_W, 1'b1, 32'h0000_03FC, 32'h0,         32'h0180_0304, 1'b0, 3};
    v[20] = '{1'b0, SZ_B, 1'b0, 32'h0000_03FF, 32'h0,         32'h0000_0004, 1'b0, 3};
    v[21] = '{1'b0, SZ_B, 1'b1, 32'h0000_03FD, 32'h0,         32'hFFFF_FF80, 1'b0, 3};
    v[22] = '{1'b0, SZ_W, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1, 1};
    v[23] = '{1'b0, SZ_W, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1, 1};

    vb[0] = '{1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 1};
    vb[1] = '{1'b1, SZ_H, 1'b0, 32'h0000_0046, 32'h0000_5566, 32'h0000_0000, 1'b0, 1};
    vb[2] = '{1'b0, SZ_W, 1'b0, 32'h0000_0040, 32'h0,         32'hAABB_CCDD, 1'b0, 1};
    vb[3] = '{1'b0, SZ_H, 1'b0, 32'h0000_0046, 32'h0,         32'h0000_5566, 1'b0, 1};
    vb[4] = '{1'b0, SZ_B, 1'b1, 32'h0000_0041, 32'h0,         32'hFFFF_FFBB, 1'b0, 1};

    a_valid = 0; a_wr = 0; a_size = 0; a_signed = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_wr = 0; b_size = 0; b_signed = 0; b_addr = 0; b_wdata = 0;

    // Reset state, with a request already offered
    rst_n = 1'b0;
    a_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready",     32'(a_ready),     32'd0);
    check("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("reset_rsp_err",   32'(a_err),       32'd0);
    check("reset_rdata",     a_rdata,          32'd0);
    check("reset_err_count", 32'(a_err_count), 32'd0);
    check("reset_ready_b",   32'(b_ready),     32'd0);
    a_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(a_ready), 32'd1);

    // Directed table on the two-wait-state instance
    for (int i = 0; i < 24; i++) begin
      do_req(v[i].wr, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd,          v[i].exp_rdata);
      check($sformatf("vec%0d_err", i),   32'(er),     32'(v[i].exp_err));
      check($sformatf("vec%0d_lat", i),   32'(lat),    32'(v[i].exp_lat));
    end
    check("err_count_after_table", 32'(a_err_count), 32'd6);

    // Saturation of the error counter
    nerr_seen = 0;
    for (int i = 0; i < 260; i++) begin
      do_req(1'b0, SZ_R, 1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
      if (er === 1'b1 && lat == 1) nerr_seen++;
    end
    check("sat_errors_flagged", 32'(nerr_seen), 32'd260);
    check("err_count_saturated", 32'(a_err_count), 32'd255);

    // Valid held high: a new request is taken on the first IDLE edge after each response
    a_valid = 1'b1; a_wr = 1'b0; a_size = SZ_W; a_signed = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
    rsp_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        if (rsp_cnt < 4) rsp_at[rsp_cnt] = i;
        rsp_cnt++;
        check("held_rdata", a_rdata, 32'hDEAD_1234);
        check("held_ready_in_resp", 32'(a_ready), 32'd0);
      end
    end
    a_valid = 1'b0;
    check("held_rsp_count", 32'(rsp_cnt), 32'd2);
    if (rsp_cnt >= 2) begin
      check("held_first_rsp", 32'(rsp_at[0]), 32'd3);
      check("held_second_rsp", 32'(rsp_at[1]), 32'd7);
    end
    repeat (6) @(negedge clk);

    // Zero wait states, valid held high across back-to-back requests
    b_valid = 1'b1;
    b_wr = vb[0].wr; b_size = vb[0].size; b_signed = vb[0].sgn; b_addr = vb[0].addr; b_wdata = vb[0].wdata;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!b_rsp_valid && guard < 8);
      check($sformatf("b%0d_rsp_valid", k), 32'(b_rsp_valid), 32'd1);
      check($sformatf("b%0d_rdata", k), b_rdata, vb[k].exp_rdata);
      check($sformatf("b%0d_err", k), 32'(b_err), 32'd0);
      check($sformatf("b%0d_ready_in_resp", k), 32'(b_ready), 32'd0);
      if (k == 0) check("b0_first_latency", 32'(guard), 32'd1);
      else        check($sformatf("b%0d_spacing", k), 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
      if (k < 4) begin
        b_wr = vb[k+1].wr; b_size = vb[k+1].size; b_signed = vb[k+1].sgn;
        b_addr = vb[k+1].addr; b_wdata = vb[k+1].wdata;
      end else begin
        b_valid = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // Reset during WAIT aborts a pending store
    a_valid = 1'b1; a_wr = 1'b1; a_size = SZ_W; a_signed = 1'b0; a_addr = 32'h20; a_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    check("abort_in_wait_ready", 32'(a_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_reset_ready",     32'(a_ready),     32'd0);
    check("abort_reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("abort_reset_rsp_err",   32'(a_err),       32'd0);
    check("abort_reset_rdata",     a_rdata,          32'd0);
    check("abort_reset_err_count", 32'(a_err_count), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_reset_held_valid", 32'(a_rsp_valid), 32'd0);
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_rsp_valid) rsp_cnt++;
    end
    check("abort_no_response", 32'(rsp_cnt), 32'd0);
    do_req(1'b0, SZ_W, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
    check("abort_mem_unchanged", rd, 32'h1122_3344);
    check("abort_load_lat", 32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
